memory_interface_arbiter: RTL and testbench
===========================================

Name: memory_interface_arbiter

Overview:
- Shares the core's single data/instruction memory interface between two requesters: instruction fetch and the load/store path.
- Arbitrates between them, sequences one transaction at a time, and drives the shared bus with enable, read/write state, word address and byte frame mask.
- Registers the read data and completion back to the winning requester.
- A wait-state timeout counter bounds each access and reports an error if memory never responds.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in an access state before abort with error; 0 disables timeout.
- TIMEOUT_WIDTH, 8: counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_request  in  1  fetch wants a read; held high until fetch_done.
- fetch_address  in  32  fetch byte address; stable while request high.
- fetch_done  out  1  one-cycle completion pulse.
- fetch_data  out  32  read word; valid when fetch_done = 1.
- fetch_error  out  1  qualifies fetch_done; 1 = timed out.
- lsu_request  in  1  load/store wants an access; held high until lsu_done.
- lsu_write  in  1  0 = read, 1 = write.
- lsu_address  in  32  word-aligned address.
- lsu_frame_mask  in  4  byte lanes.
- lsu_store_data  in  32  write data, already lane-positioned.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_load_data  out  32  read word; valid when lsu_done = 1.
- lsu_error  out  1  qualifies lsu_done; 1 = timed out.
- memory_interface_enable  out  1  access in progress.
- memory_interface_memory_state  out  1  0 = READ, 1 = WRITE.
- memory_interface_address  out  32  word address, bits [1:0] = 00.
- memory_interface_frame_mask  out  4  byte-lane mask.
- memory_interface_write_data  out  32  store data.
- memory_interface_read_data  in  32  read data; sampled when ready = 1.
- memory_interface_ready  in  1  memory completes the current access this cycle.

Behaviour:
- States: IDLE, FETCH_ACCESS, LSU_ACCESS. Encoding is free.
- Reset (async, reset_n = 0):
  - State goes to IDLE and the timeout counter is cleared.
  - All outputs go to 0: done, error, data, enable, state, address, mask, write_data.
  - Reset mid-access aborts the access silently: no done pulse; a later memory_interface_ready is ignored.
- IDLE:
  - Enable = 0; bus address, mask and write_data = 0.
  - A requester whose done output is 1 in this cycle is not eligible. Its request is stale, having just completed.
  - Both eligible: LSU wins (fixed priority, avoids load/store starvation deadlock). Only one eligible: it wins. None: stay in IDLE.
  - The grant registers the bus outputs at the clock edge; enable = 1 from the next cycle.
- FETCH_ACCESS:
  - state = READ; address = {fetch_address[31:2],2'b00}; mask = 4'b1111; write_data = 0.
- LSU_ACCESS:
  - state = lsu_write; address and mask passed through from lsu_address and lsu_frame_mask.
  - write_data = lsu_store_data when lsu_write = 1, else 0.
- Bus outputs are held constant for the whole access state.
- Completion (in an access state with memory_interface_ready = 1):
  - Next edge: state = IDLE; the granted done = 1 for exactly one cycle; error = 0.
  - Data = memory_interface_read_data for reads, 0 for writes.
  - Enable drops in that same cycle.
- Timeout:
  - The counter increments each access cycle without ready and clears on entering IDLE.
  - On reaching TIMEOUT_CYCLES: done = 1, error = 1, data = 0, state = IDLE.
  - If ready arrives in the same cycle as expiry, ready wins (normal completion).
- Latency with a zero-wait memory: request seen in IDLE at cycle 0; enable high at cycle 1; ready at cycle 1; done at cycle 2. The next grant is possible at cycle 3 at the earliest.
- Non-granted done/error outputs stay 0. Data outputs hold their last value between pulses.
- Requests are not cancellable. Dropping a request mid-access is a protocol violation; the access still completes and the done pulse is still produced.

Optional Feature:
- Macro: ARBITER_ROUND_ROBIN_EN.
- Defined: adds a 1-bit last_grant register (reset value = FETCH). When both requesters are eligible in IDLE, the one not in last_grant wins; last_grant updates on every grant.
- Undefined: fixed LSU priority as described above; no last_grant register.

Test Plan:
- Fetch only, fetch_address = 0x0000_1006, memory returns 0xDEAD_BEEF with ready at the 3rd access cycle:
  - bus shows address 0x0000_1004, mask 1111, READ.
  - fetch_done pulses once with fetch_data = 0xDEAD_BEEF and fetch_error = 0.
- LSU store: lsu_address = 0x200, mask 0100, store_data = 0x0000_AB00, zero-wait memory:
  - bus WRITE with the same address/mask/data.
  - lsu_done at cycle 2 with lsu_load_data = 0.
- Both requesting in the same cycle, fixed priority:
  - LSU is served first, then fetch.
  - The stale LSU request in its done cycle does not re-grant; exactly one lsu_done and one fetch_done are produced.
- Timeout with TIMEOUT_CYCLES = 4 and memory never ready: fetch_done with fetch_error = 1 and fetch_data = 0 after 4 access cycles; enable returns to 0.
- Assert reset_n low during LSU_ACCESS: all outputs 0 immediately; a later ready pulse produces no lsu_done; normal operation after release.
- With ARBITER_ROUND_ROBIN_EN, both requesting continuously: grants alternate LSU, fetch, LSU, fetch.

Source files
------------

// File: rtl/memory_interface_arbiter.sv
// memory_interface_arbiter: shares one memory bus between instruction fetch and the load/store unit.
//
// Ports:
//   clk, reset_n                       core clock (rising edge), asynchronous active-low reset
//   fetch_request/address              fetch read request (held until fetch_done)
//   fetch_done/data/error              registered completion pulse, read word, timeout flag
//   lsu_request/write/address/
//   lsu_frame_mask/store_data          load/store request (held until lsu_done)
//   lsu_done/load_data/error           registered completion pulse, read word, timeout flag
//   memory_interface_enable/
//   memory_state/address/frame_mask/
//   write_data                         registered shared bus outputs, constant during an access
//   memory_interface_read_data/ready   memory response, sampled when ready = 1
//
// Parameters:
//   TIMEOUT_CYCLES  access cycles without ready before abort with error (0 = no timeout)
//   TIMEOUT_WIDTH   wait counter width, 2**TIMEOUT_WIDTH > TIMEOUT_CYCLES
//
// Optional feature: define ARBITER_ROUND_ROBIN_EN to alternate grants when both
// requesters are eligible; otherwise the LSU has fixed priority.
module memory_interface_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    output logic        fetch_done,
    output logic [31:0] fetch_data,
    output logic        fetch_error,
    input  logic        lsu_request,
    input  logic        lsu_write,
    input  logic [31:0] lsu_address,
    input  logic [3:0]  lsu_frame_mask,
    input  logic [31:0] lsu_store_data,
    output logic        lsu_done,
    output logic [31:0] lsu_load_data,
    output logic        lsu_error,
    output logic        memory_interface_enable,
    output logic        memory_interface_memory_state,
    output logic [31:0] memory_interface_address,
    output logic [3:0]  memory_interface_frame_mask,
    output logic [31:0] memory_interface_write_data,
    input  logic [31:0] memory_interface_read_data,
    input  logic        memory_interface_ready
);
    typedef enum logic [1:0] {IDLE, FETCH_ACCESS, LSU_ACCESS} state_t;

    localparam bit                     TO_EN = TIMEOUT_CYCLES != 0;
    localparam logic [TIMEOUT_WIDTH-1:0] TMAX  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     en_q, en_d, wr_q, wr_d;
    logic [31:0]              addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]               mask_q, mask_d;
    logic                     fetch_done_q, fetch_done_d, fetch_error_q, fetch_error_d;
    logic [31:0]              fetch_data_q, fetch_data_d;
    logic                     lsu_done_q, lsu_done_d, lsu_error_q, lsu_error_d;
    logic [31:0]              lsu_data_q, lsu_data_d;
    logic                     fetch_elig, lsu_elig, grant_lsu, expired;
    logic                     unused;

    // Fetch addresses are forced to word alignment, so the byte offset is dropped.
    assign unused = ^fetch_address[1:0];

    // A requester in its done cycle still shows its just-served request.
    assign fetch_elig = fetch_request && !fetch_done_q;
    assign lsu_elig   = lsu_request && !lsu_done_q;
    assign expired    = TO_EN && cnt_q == TMAX;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;  // 0 = FETCH, 1 = LSU
    assign grant_lsu = lsu_elig && (!fetch_elig || !last_grant_q);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last_grant_q <= 1'b0;
        else          last_grant_q <= last_grant_d;
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (lsu_elig || fetch_elig)) last_grant_d = grant_lsu;
    end
`else
    assign grant_lsu = lsu_elig;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        en_d          = en_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        mask_d        = mask_q;
        wdata_d       = wdata_q;
        fetch_done_d  = 1'b0;
        fetch_error_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        lsu_done_d    = 1'b0;
        lsu_error_d   = 1'b0;
        lsu_data_d    = lsu_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_lsu) begin
                    state_d = LSU_ACCESS;
                    en_d    = 1'b1;
                    wr_d    = lsu_write;
                    addr_d  = lsu_address;
                    mask_d  = lsu_frame_mask;
                    wdata_d = lsu_write ? lsu_store_data : '0;
                end else if (fetch_elig) begin
                    state_d = FETCH_ACCESS;
                    en_d    = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = {fetch_address[31:2], 2'b00};
                    mask_d  = 4'b1111;
                    wdata_d = '0;
                end
            end
            FETCH_ACCESS, LSU_ACCESS: begin
                // Ready in the expiry cycle still counts as a normal completion.
                if (memory_interface_ready || expired) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    mask_d  = '0;
                    wdata_d = '0;
                    if (state_q == FETCH_ACCESS) begin
                        fetch_done_d  = 1'b1;
                        fetch_error_d = !memory_interface_ready;
                        fetch_data_d  = memory_interface_ready ? memory_interface_read_data : '0;
                    end else begin
                        lsu_done_d  = 1'b1;
                        lsu_error_d = !memory_interface_ready;
                        lsu_data_d  = (memory_interface_ready && !wr_q) ? memory_interface_read_data : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            en_q          <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            mask_q        <= '0;
            wdata_q       <= '0;
            fetch_done_q  <= 1'b0;
            fetch_error_q <= 1'b0;
            fetch_data_q  <= '0;
            lsu_done_q    <= 1'b0;
            lsu_error_q   <= 1'b0;
            lsu_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            mask_q        <= mask_d;
            wdata_q       <= wdata_d;
            fetch_done_q  <= fetch_done_d;
            fetch_error_q <= fetch_error_d;
            fetch_data_q  <= fetch_data_d;
            lsu_done_q    <= lsu_done_d;
            lsu_error_q   <= lsu_error_d;
            lsu_data_q    <= lsu_data_d;
        end
    end

    assign fetch_done                    = fetch_done_q;
    assign fetch_error                   = fetch_error_q;
    assign fetch_data                    = fetch_data_q;
    assign lsu_done                      = lsu_done_q;
    assign lsu_error                     = lsu_error_q;
    assign lsu_load_data                 = lsu_data_q;
    assign memory_interface_enable       = en_q;
    assign memory_interface_memory_state = wr_q;
    assign memory_interface_address      = addr_q;
    assign memory_interface_frame_mask   = mask_q;
    assign memory_interface_write_data   = wdata_q;
endmodule

// File: tb/tb_memory_interface_arbiter.sv
// tb_memory_interface_arbiter: directed self-checking bench for memory_interface_arbiter.
module tb_memory_interface_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_request = 1'b0;
    logic [31:0] fetch_address = '0;
    logic        fetch_done, fetch_error;
    logic [31:0] fetch_data;
    logic        lsu_request = 1'b0, lsu_write = 1'b0;
    logic [31:0] lsu_address = '0, lsu_store_data = '0;
    logic [3:0]  lsu_frame_mask = '0;
    logic        lsu_done, lsu_error;
    logic [31:0] lsu_load_data;
    logic        en, mstate;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mmask;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;

    int checks = 0;
    int fails  = 0;

    memory_interface_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_request(fetch_request), .fetch_address(fetch_address),
        .fetch_done(fetch_done), .fetch_data(fetch_data), .fetch_error(fetch_error),
        .lsu_request(lsu_request), .lsu_write(lsu_write), .lsu_address(lsu_address),
        .lsu_frame_mask(lsu_frame_mask), .lsu_store_data(lsu_store_data),
        .lsu_done(lsu_done), .lsu_load_data(lsu_load_data), .lsu_error(lsu_error),
        .memory_interface_enable(en), .memory_interface_memory_state(mstate),
        .memory_interface_address(maddr), .memory_interface_frame_mask(mmask),
        .memory_interface_write_data(mwdata),
        .memory_interface_read_data(rdata), .memory_interface_ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        tick();
        checks++;
        if ({fetch_done, fetch_error, lsu_done, lsu_error, en, mstate, mmask} !== 10'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0", {fetch_done, fetch_error, lsu_done, lsu_error, en, mstate, mmask});
        end
        checks++;
        if ({fetch_data, lsu_load_data, maddr, mwdata} !== 128'd0) begin
            fails++;
            $display("FAIL reset_data: got %h required 0", {fetch_data, lsu_load_data, maddr, mwdata});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch;
        fetch_request = 1'b1;
        fetch_address = 32'h0000_1006;
        tick();
        checks++;
        if ({en, mstate, maddr, mmask, mwdata} !== {1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0}) begin
            fails++;
            $display("FAIL fetch_bus: got en=%b st=%b a=%h m=%h wd=%h required 1 0 00001004 f 0", en, mstate, maddr, mmask, mwdata);
        end
        tick();
        tick();
        checks++;
        if ({en, fetch_done, maddr} !== {1'b1, 1'b0, 32'h0000_1004}) begin
            fails++;
            $display("FAIL fetch_wait: got en=%b done=%b a=%h required 1 0 00001004", en, fetch_done, maddr);
        end
        ready = 1'b1;
        rdata = 32'hDEAD_BEEF;
        tick();
        ready = 1'b0;
        rdata = '0;
        checks++;
        if ({fetch_done, fetch_error, fetch_data, en, lsu_done} !== {2'b10, 32'hDEAD_BEEF, 2'b00}) begin
            fails++;
            $display("FAIL fetch_done: got done=%b err=%b d=%h en=%b ldone=%b required 1 0 deadbeef 0 0", fetch_done, fetch_error, fetch_data, en, lsu_done);
        end
        tick();
        fetch_request = 1'b0;
        checks++;
        if ({fetch_done, en, fetch_data} !== {2'b00, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL fetch_stale: got done=%b en=%b d=%h required 0 0 deadbeef", fetch_done, en, fetch_data);
        end
        tick();
    endtask

    task automatic test_both;
        fetch_request  = 1'b1;
        fetch_address  = 32'h0000_2000;
        lsu_request    = 1'b1;
        lsu_write      = 1'b0;
        lsu_address    = 32'h0000_0300;
        lsu_frame_mask = 4'hF;
        tick();
        checks++;
        if ({en, mstate, maddr} !== {2'b10, 32'h0000_0300}) begin
            fails++;
            $display("FAIL both_first: got en=%b st=%b a=%h required 1 0 00000300", en, mstate, maddr);
        end
        ready = 1'b1;
        rdata = 32'h1111_1111;
        tick();
        ready = 1'b0;
        checks++;
        if ({lsu_done, lsu_error, lsu_load_data, fetch_done} !== {2'b10, 32'h1111_1111, 1'b0}) begin
            fails++;
            $display("FAIL both_lsu_done: got done=%b err=%b d=%h fdone=%b required 1 0 11111111 0", lsu_done, lsu_error, lsu_load_data, fetch_done);
        end
        tick();
        lsu_request = 1'b0;
        checks++;
        if ({en, maddr, lsu_done} !== {1'b1, 32'h0000_2000, 1'b0}) begin
            fails++;
            $display("FAIL both_second: got en=%b a=%h ldone=%b required 1 00002000 0", en, maddr, lsu_done);
        end
        ready = 1'b1;
        rdata = 32'h2222_2222;
        tick();
        ready = 1'b0;
        checks++;
        if ({fetch_done, fetch_data, lsu_done, lsu_load_data} !== {1'b1, 32'h2222_2222, 1'b0, 32'h1111_1111}) begin
            fails++;
            $display("FAIL both_fetch_done: got fd=%b d=%h ld=%b ldata=%h required 1 22222222 0 11111111", fetch_done, fetch_data, lsu_done, lsu_load_data);
        end
        tick();
        fetch_request = 1'b0;
        checks++;
        if ({en, fetch_done, lsu_done} !== 3'b000) begin
            fails++;
            $display("FAIL both_idle: got en=%b fd=%b ld=%b required 000", en, fetch_done, lsu_done);
        end
        tick();
    endtask

    task automatic test_store;
        lsu_request    = 1'b1;
        lsu_write      = 1'b1;
        lsu_address    = 32'h0000_0200;
        lsu_frame_mask = 4'b0100;
        lsu_store_data = 32'h0000_AB00;
        tick();
        checks++;
        if ({en, mstate, maddr, mmask, mwdata} !== {2'b11, 32'h0000_0200, 4'b0100, 32'h0000_AB00}) begin
            fails++;
            $display("FAIL store_bus: got en=%b st=%b a=%h m=%b wd=%h required 1 1 00000200 0100 0000ab00", en, mstate, maddr, mmask, mwdata);
        end
        ready = 1'b1;
        rdata = 32'hFFFF_FFFF;
        tick();
        ready = 1'b0;
        checks++;
        if ({lsu_done, lsu_error, lsu_load_data, en, mwdata} !== {2'b10, 32'h0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL store_done: got done=%b err=%b d=%h en=%b wd=%h required 1 0 0 0 0", lsu_done, lsu_error, lsu_load_data, en, mwdata);
        end
        tick();
        lsu_request = 1'b0;
        lsu_write   = 1'b0;
        checks++;
        if ({lsu_done, en} !== 2'b00) begin
            fails++;
            $display("FAIL store_stale: got done=%b en=%b required 00", lsu_done, en);
        end
        tick();
    endtask

    task automatic test_timeout;
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0040;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if ({en, fetch_done} !== 2'b10) begin
            fails++;
            $display("FAIL timeout_wait: got en=%b done=%b required 10", en, fetch_done);
        end
        tick();
        checks++;
        if ({fetch_done, fetch_error, fetch_data, en} !== {2'b11, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL timeout_done: got done=%b err=%b d=%h en=%b required 1 1 0 0", fetch_done, fetch_error, fetch_data, en);
        end
        tick();
        fetch_request = 1'b0;
        checks++;
        if ({fetch_done, fetch_error, en} !== 3'b000) begin
            fails++;
            $display("FAIL timeout_after: got done=%b err=%b en=%b required 000", fetch_done, fetch_error, en);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        lsu_request    = 1'b1;
        lsu_write      = 1'b0;
        lsu_address    = 32'h0000_0080;
        lsu_frame_mask = 4'hF;
        tick();
        checks++;
        if ({en, maddr} !== {1'b1, 32'h0000_0080}) begin
            fails++;
            $display("FAIL rmid_grant: got en=%b a=%h required 1 00000080", en, maddr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({en, mstate, maddr, mmask, lsu_done} !== 42'd0) begin
            fails++;
            $display("FAIL rmid_async: got en=%b a=%h m=%h ld=%b required 0", en, maddr, mmask, lsu_done);
        end
        tick();
        lsu_request = 1'b0;
        reset_n = 1'b1;
        ready = 1'b1;
        rdata = 32'h1234_5678;
        tick();
        ready = 1'b0;
        checks++;
        if ({lsu_done, en, lsu_load_data} !== 34'd0) begin
            fails++;
            $display("FAIL rmid_ignored: got ld=%b en=%b d=%h required 0", lsu_done, en, lsu_load_data);
        end
        lsu_request = 1'b1;
        lsu_address = 32'h0000_0084;
        tick();
        ready = 1'b1;
        rdata = 32'h55AA_55AA;
        tick();
        ready = 1'b0;
        checks++;
        if ({lsu_done, lsu_error, lsu_load_data} !== {2'b10, 32'h55AA_55AA}) begin
            fails++;
            $display("FAIL rmid_recover: got done=%b err=%b d=%h required 1 0 55aa55aa", lsu_done, lsu_error, lsu_load_data);
        end
        tick();
        lsu_request = 1'b0;
        tick();
    endtask

`ifdef ARBITER_ROUND_ROBIN_EN
    task automatic test_round_robin;
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h0000_2000;
        exp_addr[1] = 32'h0000_1000;
        exp_addr[2] = 32'h0000_2000;
        exp_addr[3] = 32'h0000_1000;
        do_reset();
        fetch_address  = 32'h0000_1000;
        lsu_address    = 32'h0000_2000;
        lsu_write      = 1'b0;
        lsu_frame_mask = 4'hF;
        ready          = 1'b1;
        fetch_request  = 1'b1;
        lsu_request    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({en, maddr} !== {1'b1, exp_addr[i]}) begin
                fails++;
                $display("FAIL rr_grant%0d: got en=%b a=%h required 1 %h", i, en, maddr, exp_addr[i]);
            end
            tick();
        end
        fetch_request = 1'b0;
        tick();
        lsu_request = 1'b0;
        tick();
        tick();
        fetch_request = 1'b1;
        lsu_request   = 1'b1;
        tick();
        checks++;
        if ({en, maddr} !== {1'b1, 32'h0000_1000}) begin
            fails++;
            $display("FAIL rr_after_lsu: got en=%b a=%h required 1 00001000", en, maddr);
        end
        tick();
        fetch_request = 1'b0;
        lsu_request   = 1'b0;
        ready         = 1'b0;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_store();
        test_timeout();
        test_reset_mid();
`ifdef ARBITER_ROUND_ROBIN_EN
        test_round_robin();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
